ingress_cmd_parser: RTL and testbench
=====================================

INGRESS_CMD_PARSER -- requirements
Module: ingress_cmd_parser

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter: SYNC_BYTE, 8'hCD, required value of header word0[31:24].
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-low reset (rst==0 resets).
REQ-005 i_in_ready  input  2  ingress ping-pong FIFO side ready flags.
REQ-006 o_in_activate  output  2  one-hot claim of a ready FIFO side.
REQ-007 i_in_size  input  24  word count of the activated side.
REQ-008 i_in_data  input  32  first-word-fall-through data of the activated side.
REQ-009 o_in_stb  output  1  pop one word; i_in_data advances next cycle.
REQ-010 i_master_ready  input  1  downstream command consumer idle.
REQ-011 o_command / o_flag  output  8 / 8  latched command and flag bytes.
REQ-012 o_rw_count / o_address  output  32 / 32  latched count and address.
REQ-013 o_command_rdy_stb  output  1  one-cycle pulse; command fields valid.
REQ-014 o_wdata  output  32; o_wdata_stb  output  1; i_wdata_ready  input  1: write-payload stream.
REQ-015 o_sync_err_count  output  8  saturating count of discarded non-sync words.
REQ-016 o_busy  output  1  high whenever state != SYNC.

Function
REQ-017 FIFO claim: when o_in_activate==0 and i_in_ready!=0, set bit0 if i_in_ready[0], else bit1; clear word counter to 0.
REQ-018 Word available when o_in_activate!=0 and counter < i_in_size; each o_in_stb pulse increments counter; at most one pop per cycle, consecutive pops allowed.
REQ-019 Release: o_in_activate<=0 the cycle after counter==i_in_size with no pop pending; size 0 releases one cycle after claim.
REQ-020 States: SYNC, CNT, ADDR, ISSUE, PAYLOAD; popping occurs only in SYNC, CNT, ADDR and PAYLOAD.
REQ-021 SYNC: on available word, pop; if data[31:24]==SYNC_BYTE latch o_flag=data[23:16], o_command=data[7:0] -> CNT; else o_sync_err_count+1 (saturate at 255), stay.
REQ-022 CNT: on available word, pop, latch o_rw_count -> ADDR. ADDR: pop, latch o_address -> ISSUE.
REQ-023 ISSUE: no pop; when i_master_ready==1 pulse o_command_rdy_stb exactly one cycle; then PAYLOAD if o_command==`WRITE_COMMAND and o_rw_count!=0, else SYNC.
REQ-024 PAYLOAD: pop only when word available and i_wdata_ready==1; o_wdata<=data and o_wdata_stb=1 on the cycle after the pop; payload counter 32-bit; -> SYNC after o_rw_count words.
REQ-025 Header and payload may span a FIFO side release and re-claim; state and counters persist across sides.
REQ-026 o_command/o_flag/o_rw_count/o_address hold their values from latch until overwritten by the next header; never cleared except by reset.
REQ-027 Minimum header-to-strobe latency: 3 pops + 1 cycle when words are continuously available and i_master_ready is high.

Reset
REQ-028 On rst==0: state SYNC; all outputs 0 (o_in_activate=0, o_in_stb=0, o_command_rdy_stb=0, o_wdata_stb=0, o_wdata=0, latched fields 0, o_sync_err_count=0, o_busy=0); counters 0.
REQ-029 Reset mid-operation aborts any header or payload and releases the claimed FIFO side; words already popped are lost.

Verification
REQ-030 Side0 size 3: {CD,05,00,00},0,0x100 with PING_COMMAND=00 -> one o_command_rdy_stb, o_flag=05, o_address=0x100, back to SYNC, side released.
REQ-031 Side1 size 5: WRITE header rw_count=2, then 0xA,0xB, i_wdata_ready toggling -> o_wdata_stb twice with 0xA,0xB, no pop while i_wdata_ready=0.
REQ-032 Two garbage words 0x12345678 before valid header -> o_sync_err_count=2, header then parsed normally; 300 garbage words -> count saturates at 255.
REQ-033 i_master_ready held 0 for 20 cycles in ISSUE -> no pop, no strobe; strobe one cycle after ready rises.
REQ-034 Header split: side0 size 2 (word0,word1), side1 size 1 (address) -> single correct command strobe.
REQ-035 rst=0 asserted during PAYLOAD -> all outputs 0 next cycle, state SYNC, o_in_activate=0.

Source files
------------

// File: rtl/ingress_cmd_parser.sv
// ingress_cmd_parser: claims ping-pong FIFO sides (i_in_*/o_in_*), parses sync/count/address headers into latched command fields with a o_command_rdy_stb handshake on i_master_ready, streams write payload on o_wdata*, reports o_sync_err_count/o_busy
module ingress_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE     = 8'hCD,
  parameter logic [7:0] WRITE_COMMAND = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_in_ready,
  output logic [1:0]  o_in_activate,
  input  logic [23:0] i_in_size,
  input  logic [31:0] i_in_data,
  output logic        o_in_stb,
  input  logic        i_master_ready,
  output logic [7:0]  o_command,
  output logic [7:0]  o_flag,
  output logic [31:0] o_rw_count,
  output logic [31:0] o_address,
  output logic        o_command_rdy_stb,
  output logic [31:0] o_wdata,
  output logic        o_wdata_stb,
  input  logic        i_wdata_ready,
  output logic [7:0]  o_sync_err_count,
  output logic        o_busy
);
  typedef enum logic [2:0] {SYNC, CNT, ADDR, ISSUE, PAYLOAD} state_t;
  state_t state, state_nx;
  logic [23:0] word_cnt;
  logic [31:0] pay_cnt;
  logic avail, pop, sync_hit;
  assign avail = |o_in_activate && word_cnt < i_in_size;
  assign sync_hit = i_in_data[31:24] == SYNC_BYTE;
  always_ff @(posedge clk) state <= !rst ? SYNC : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    state_nx = pop && sync_hit ? CNT : SYNC;
      CNT:     state_nx = pop ? ADDR : CNT;
      ADDR:    state_nx = pop ? ISSUE : ADDR;
      ISSUE:   state_nx = !i_master_ready ? ISSUE : o_command == WRITE_COMMAND && o_rw_count != 32'd0 ? PAYLOAD : SYNC;
      PAYLOAD: state_nx = pop && pay_cnt + 32'd1 == o_rw_count ? SYNC : PAYLOAD;
      default: state_nx = SYNC;
    endcase
  end
  always_comb begin
    o_busy = state != SYNC;
    pop = rst && avail && state != ISSUE && (state != PAYLOAD || i_wdata_ready);
    o_in_stb = pop;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_in_activate <= '0;
      word_cnt <= '0;
      pay_cnt <= '0;
      o_command <= '0;
      o_flag <= '0;
      o_rw_count <= '0;
      o_address <= '0;
      o_command_rdy_stb <= 1'b0;
      o_wdata <= '0;
      o_wdata_stb <= 1'b0;
      o_sync_err_count <= '0;
    end else begin
      if (o_in_activate == 2'b00 && i_in_ready != 2'b00) begin
        o_in_activate <= i_in_ready[0] ? 2'b01 : 2'b10;
        word_cnt <= '0;
      end else if (pop) word_cnt <= word_cnt + 24'd1;
      else if (|o_in_activate && !avail) o_in_activate <= '0;
      o_command_rdy_stb <= state == ISSUE && i_master_ready;
      o_wdata_stb <= pop && state == PAYLOAD;
      if (pop && state == PAYLOAD) o_wdata <= i_in_data;
      pay_cnt <= state == ISSUE ? 32'd0 : pop && state == PAYLOAD ? pay_cnt + 32'd1 : pay_cnt;
      if (pop && state == SYNC && sync_hit) begin
        o_flag <= i_in_data[23:16];
        o_command <= i_in_data[7:0];
      end
      if (pop && state == SYNC && !sync_hit && o_sync_err_count != 8'hFF) o_sync_err_count <= o_sync_err_count + 8'd1;
      if (pop && state == CNT) o_rw_count <= i_in_data;
      if (pop && state == ADDR) o_address <= i_in_data;
    end
  end
endmodule

// File: tb/tb_ingress_cmd_parser.sv
// tb_ingress_cmd_parser: directed and randomized stream checks of ingress_cmd_parser against a generated-stream reference
module tb_ingress_cmd_parser;
  logic clk = 0, rst = 0;
  logic [1:0] i_in_ready, o_in_activate;
  logic [23:0] i_in_size;
  logic [31:0] i_in_data, o_rw_count, o_address, o_wdata;
  logic o_in_stb, i_master_ready, o_command_rdy_stb, o_wdata_stb, i_wdata_ready, o_busy;
  logic [7:0] o_command, o_flag, o_sync_err_count;
  int n_chk = 0, n_err = 0;
  logic [31:0] feed_w[$];
  int feed_sz[$], feed_side[$];
  logic [31:0] side_w[2][64];
  int side_sz[2], side_idx[2];
  logic [1:0] rdy = 2'b00, act_seen = 2'b00;
  logic last_stb = 0, prev_stb = 0;
  int last_side = 0, ds = 0, dn = 0;
  int pop_total = 0, cyc = 0, first_pop_cyc = 0, stb_cyc = 0, gate_from = 0, gate_viol = 0, overrun = 0;
  int mr_mode = 0, wr_mode = 0;
  logic [79:0] got_cmd[$], exp_cmd[$];
  logic [31:0] got_wd[$], exp_wd[$], tw[$];
  always #5 clk = ~clk;
  ingress_cmd_parser dut (
    .clk(clk), .rst(rst), .i_in_ready(i_in_ready), .o_in_activate(o_in_activate),
    .i_in_size(i_in_size), .i_in_data(i_in_data), .o_in_stb(o_in_stb),
    .i_master_ready(i_master_ready), .o_command(o_command), .o_flag(o_flag),
    .o_rw_count(o_rw_count), .o_address(o_address), .o_command_rdy_stb(o_command_rdy_stb),
    .o_wdata(o_wdata), .o_wdata_stb(o_wdata_stb), .i_wdata_ready(i_wdata_ready),
    .o_sync_err_count(o_sync_err_count), .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic blk(input int side, input int n);
    feed_side.push_back(side);
    feed_sz.push_back(n);
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    rst = 0;
    feed_w.delete(); feed_sz.delete(); feed_side.delete();
    got_cmd.delete(); got_wd.delete();
    rdy = 0; last_stb = 0; act_seen = 0;
    pop_total = 0; gate_from = 0; gate_viol = 0; overrun = 0;
    mr_mode = 0; wr_mode = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask
  task automatic wait_idle(input string tag, input int lim);
    logic done;
    done = 0;
    for (int k = 0; k < lim && !done; k++) begin
      @(posedge clk); #3;
      done = feed_sz.size() == 0 && rdy == 0 && o_in_activate == 0 && !o_busy;
    end
    repeat (2) @(posedge clk);
    #3 chk({tag, "_idle"}, done, 1);
  endtask
  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(posedge clk); #2;
    i_master_ready = mr_mode == 0 ? 1'b1 : mr_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    i_wdata_ready = wr_mode == 0 ? 1'b1 : wr_mode == 1 ? ~i_wdata_ready : wr_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  // FIFO side emulator: loads blocks in feed order, at most one side waiting for a claim
  initial forever begin
    @(negedge clk);
    if (last_stb) side_idx[last_side]++;
    for (int s = 0; s < 2; s++) if (o_in_activate[s]) rdy[s] = 0;
    act_seen |= o_in_activate;
    if (rdy == 0 && feed_sz.size() > 0 && $urandom_range(0, 2) != 0) begin
      ds = feed_side[0];
      if (ds == 2) begin
        ds = int'($urandom_range(0, 1));
        if (o_in_activate[ds]) ds = 1 - ds;
      end
      if (!o_in_activate[ds]) begin
        dn = feed_sz.pop_front();
        void'(feed_side.pop_front());
        for (int k = 0; k < dn; k++) side_w[ds][k] = feed_w.pop_front();
        side_sz[ds] = dn;
        side_idx[ds] = 0;
        rdy[ds] = 1;
      end
    end
    i_in_ready = rdy;
    last_side = o_in_activate[1] ? 1 : 0;
    i_in_size = o_in_activate != 0 ? 24'(side_sz[last_side]) : 24'd0;
    i_in_data = (o_in_activate != 0 && side_idx[last_side] < side_sz[last_side]) ? side_w[last_side][side_idx[last_side]] : 32'hDEAD_BEEF;
    #1;
    last_stb = o_in_stb;
    if (o_in_stb) begin
      if (o_in_activate == 0 || side_idx[last_side] >= side_sz[last_side]) overrun++;
      pop_total++;
      if (pop_total == 1) first_pop_cyc = cyc;
      if (gate_from > 0 && pop_total > gate_from && !i_wdata_ready) gate_viol++;
    end
  end
  initial forever begin
    @(negedge clk); #2;
    if (o_command_rdy_stb) begin
      got_cmd.push_back({o_command, o_flag, o_rw_count, o_address});
      stb_cyc = cyc;
      chk("stb_width", prev_stb, 0);
    end
    if (o_wdata_stb) got_wd.push_back(o_wdata);
    prev_stb = o_command_rdy_stb;
  end
  initial begin
    #900000;
    $display("FAIL watchdog pops %0d cmds %0d", pop_total, got_cmd.size());
    $fatal(1);
  end
  initial begin
    logic [31:0] w, cnt, addr;
    logic [7:0] c, f;
    int g, n_g, n;
    i_in_ready = 0; i_in_size = 0; i_in_data = 0; i_master_ready = 1; i_wdata_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_activate", o_in_activate, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fields", {o_command, o_flag, o_rw_count, o_address}, 0);
    chk("rst_strobes", {o_in_stb, o_command_rdy_stb, o_wdata_stb}, 0);
    chk("rst_wdata_err", {o_wdata, o_sync_err_count}, 0);
    rst = 1;
    // ping on side0, continuous data: strobe 4 cycles after first pop
    feed_w.push_back(32'hCD05_0000); feed_w.push_back(32'h0); feed_w.push_back(32'h100);
    blk(0, 3);
    wait_idle("ping", 200);
    chk("ping_ncmd", got_cmd.size(), 1);
    chk("ping_fields", got_cmd.size() > 0 ? got_cmd[0] : '1, {8'h00, 8'h05, 32'h0, 32'h100});
    chk("ping_latency", stb_cyc - first_pop_cyc, 4);
    chk("ping_sides", act_seen, 2'b01);
    // write on side1 with toggling wdata_ready
    do_reset();
    wr_mode = 1; gate_from = 3;
    feed_w.push_back(32'hCD00_0001); feed_w.push_back(32'h2); feed_w.push_back(32'h40);
    feed_w.push_back(32'hA); feed_w.push_back(32'hB);
    blk(1, 5);
    wait_idle("write", 200);
    chk("write_ncmd", got_cmd.size(), 1);
    chk("write_fields", got_cmd.size() > 0 ? got_cmd[0] : '1, {8'h01, 8'h00, 32'h2, 32'h40});
    chk("write_nwd", got_wd.size(), 2);
    chk("write_wd0", got_wd.size() > 0 ? got_wd[0] : '1, 32'hA);
    chk("write_wd1", got_wd.size() > 1 ? got_wd[1] : '1, 32'hB);
    chk("write_gate", gate_viol, 0);
    chk("write_sides", act_seen, 2'b10);
    // garbage before a header, then saturation
    do_reset();
    feed_w.push_back(32'h1234_5678); feed_w.push_back(32'h1234_5678);
    feed_w.push_back(32'hCD07_1100); feed_w.push_back(32'h5); feed_w.push_back(32'h200);
    blk(0, 5);
    wait_idle("garb", 200);
    chk("garb_err", o_sync_err_count, 2);
    chk("garb_fields", got_cmd.size() > 0 ? got_cmd[0] : '1, {8'h00, 8'h07, 32'h5, 32'h200});
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 60; k++) feed_w.push_back(32'h1234_5678);
      blk(2, 60);
    end
    wait_idle("sat", 2000);
    chk("sat_err", o_sync_err_count, 255);
    // master not ready holds ISSUE
    do_reset();
    mr_mode = 1;
    feed_w.push_back(32'hCD03_0000); feed_w.push_back(32'h1); feed_w.push_back(32'h300);
    blk(0, 3);
    for (int k = 0; k < 50 && pop_total < 3; k++) begin @(posedge clk); #3; end
    repeat (20) @(posedge clk);
    #3;
    chk("hold_pops", pop_total, 3);
    chk("hold_ncmd", got_cmd.size(), 0);
    chk("hold_busy", o_busy, 1);
    mr_mode = 0;
    @(posedge clk); #3 chk("hold_pre_stb", o_command_rdy_stb, 0);
    @(posedge clk); #3 chk("hold_stb", o_command_rdy_stb, 1);
    @(posedge clk); #3 chk("hold_post_stb", o_command_rdy_stb, 0);
    wait_idle("hold", 100);
    // header split across both sides
    do_reset();
    feed_w.push_back(32'hCD09_0000); feed_w.push_back(32'h3);
    blk(0, 2);
    feed_w.push_back(32'h300);
    blk(1, 1);
    wait_idle("split", 200);
    chk("split_ncmd", got_cmd.size(), 1);
    chk("split_fields", got_cmd.size() > 0 ? got_cmd[0] : '1, {8'h00, 8'h09, 32'h3, 32'h300});
    chk("split_sides", act_seen, 2'b11);
    // reset while stuck in PAYLOAD
    do_reset();
    wr_mode = 2;
    feed_w.push_back(32'hCD00_0001); feed_w.push_back(32'h4); feed_w.push_back(32'h500);
    feed_w.push_back(32'h1); feed_w.push_back(32'h2);
    blk(0, 5);
    for (int k = 0; k < 50 && pop_total < 3; k++) begin @(posedge clk); #3; end
    repeat (4) @(posedge clk);
    #3;
    chk("pay_busy", o_busy, 1);
    chk("pay_stalled", pop_total, 3);
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #2;
    chk("mid_rst_fields", {o_command, o_flag, o_rw_count, o_address}, 0);
    chk("mid_rst_ctl", {o_in_activate, o_in_stb, o_command_rdy_stb, o_wdata_stb, o_busy}, 0);
    chk("mid_rst_wdata_err", {o_wdata, o_sync_err_count}, 0);
    rst = 1; wr_mode = 0;
    got_cmd.delete();
    feed_w.push_back(32'hCD0A_0000); feed_w.push_back(32'h0); feed_w.push_back(32'h600);
    blk(2, 3);
    wait_idle("recover", 200);
    chk("recover_fields", got_cmd.size() == 1 ? got_cmd[0] : '1, {8'h00, 8'h0A, 32'h0, 32'h600});
    // randomized stream: expectations come from how the stream was generated
    do_reset();
    mr_mode = 2; wr_mode = 3;
    n_g = 0;
    for (int t = 0; t < 40; t++) begin
      g = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        w = $urandom;
        if (w[31:24] == 8'hCD) w[31:24] = 8'h00;
        tw.push_back(w);
        n_g++;
      end
      g = $urandom_range(0, 2);
      c = g == 0 ? 8'h01 : g == 1 ? 8'h00 : 8'($urandom);
      f = 8'($urandom);
      cnt = c == 8'h01 ? 32'($urandom_range(0, 4)) : $urandom;
      addr = $urandom;
      w = $urandom;
      tw.push_back({8'hCD, f, w[7:0], c});
      tw.push_back(cnt);
      tw.push_back(addr);
      exp_cmd.push_back({c, f, cnt, addr});
      if (c == 8'h01) for (int k = 0; k < int'(cnt); k++) begin
        w = $urandom;
        tw.push_back(w);
        exp_wd.push_back(w);
      end
    end
    while (tw.size() > 0) begin
      n = $urandom_range(0, 6);
      if (n > tw.size()) n = tw.size();
      for (int k = 0; k < n; k++) feed_w.push_back(tw.pop_front());
      blk(2, n);
    end
    wait_idle("rand", 20000);
    chk("rand_ncmd", got_cmd.size(), exp_cmd.size());
    chk("rand_nwd", got_wd.size(), exp_wd.size());
    chk("rand_err", o_sync_err_count, n_g > 255 ? 255 : n_g);
    for (int i = 0; i < exp_cmd.size(); i++) chk($sformatf("rand_cmd%0d", i), i < got_cmd.size() ? got_cmd[i] : '1, exp_cmd[i]);
    for (int i = 0; i < exp_wd.size(); i++) chk($sformatf("rand_wd%0d", i), i < got_wd.size() ? got_wd[i] : '1, exp_wd[i]);
    chk("overrun", overrun, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
